// File: rtl/debounce_bank_if.sv
// Signal bundle between raw board buttons and the debounced outputs of debounce_bank.
// The master drives raw inputs; the slave (the debouncer) drives all debounced outputs.
interface debounce_bank_if #(
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0] btn;
    logic [CHANNELS-1:0] btn_state;
    logic [CHANNELS-1:0] btn_press;
    logic [CHANNELS-1:0] btn_release;
    logic [CHANNELS-1:0] btn_held;
    logic [CHANNELS-1:0] btn_hold_p;

    modport master (
        output btn,
        input  btn_state, btn_press, btn_release, btn_held, btn_hold_p
    );

    modport slave (
        input  btn,
        output btn_state, btn_press, btn_release, btn_held, btn_hold_p
    );
endinterface

// File: rtl/debounce_bank.sv
// N-channel debouncer: 2-FF synchroniser, polarity option, press/release pulses and
// optional long-press detection. Every output is registered; channels are independent.
module debounce_bank #(
    parameter int CHANNELS      = 4,
    parameter int DEBOUNCE_TIME = 500000,
    parameter int HOLD_TIME     = 0,
    parameter int ACTIVE_LOW    = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    debounce_bank_if.slave  bus
);
    localparam int DW = $clog2(DEBOUNCE_TIME + 1);
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_TIME - 1);
    localparam logic [DW-1:0] D_ONE  = DW'(1);
    // Sync flops reset to the released raw level so reset release never looks like a press.
    localparam logic [CHANNELS-1:0] SYNC_RST =
        (ACTIVE_LOW != 0) ? {CHANNELS{1'b1}} : {CHANNELS{1'b0}};

    logic [CHANNELS-1:0] s1_q, s1_d, s2_q, s2_d, lvl;
    logic [CHANNELS-1:0] state_q, state_d;
    logic [CHANNELS-1:0] press_q, press_d, release_q, release_d;
    logic [DW-1:0]       cnt_q [CHANNELS];
    logic [DW-1:0]       cnt_d [CHANNELS];

    always_comb begin
        s1_d      = bus.btn;
        s2_d      = s1_q;
        lvl       = (ACTIVE_LOW != 0) ? ~s2_q : s2_q;
        state_d   = state_q;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_d[i] = '0;
            if (lvl[i] != state_q[i]) begin
                if (cnt_q[i] == D_LAST) begin
                    state_d[i]   = lvl[i];
                    press_d[i]   = lvl[i];
                    release_d[i] = ~lvl[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + D_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q      <= SYNC_RST;
            s2_q      <= SYNC_RST;
            state_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            state_q   <= state_d;
            press_q   <= press_d;
            release_q <= release_d;
            for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign bus.btn_state   = state_q;
    assign bus.btn_press   = press_q;
    assign bus.btn_release = release_q;

    generate
        if (HOLD_TIME > 0) begin : g_hold
            localparam int HW = $clog2(HOLD_TIME + 1);
            localparam logic [HW-1:0] H_LAST = HW'(HOLD_TIME - 1);
            localparam logic [HW-1:0] H_MAX  = HW'(HOLD_TIME);
            localparam logic [HW-1:0] H_ONE  = HW'(1);

            logic [HW-1:0]       hcnt_q [CHANNELS];
            logic [HW-1:0]       hcnt_d [CHANNELS];
            logic [CHANNELS-1:0] held_q, held_d, hold_p_q, hold_p_d;

            // hcnt saturates at HOLD_TIME, so the H_LAST match (and the pulse) fires once per press.
            always_comb begin
                held_d   = held_q;
                hold_p_d = '0;
                for (int i = 0; i < CHANNELS; i++) begin
                    hcnt_d[i] = hcnt_q[i];
                    if (!state_q[i] || release_d[i]) begin
                        hcnt_d[i] = '0;
                        held_d[i] = 1'b0;
                    end else begin
                        if (hcnt_q[i] != H_MAX) hcnt_d[i] = hcnt_q[i] + H_ONE;
                        if (hcnt_q[i] == H_LAST) begin
                            held_d[i]   = 1'b1;
                            hold_p_d[i] = 1'b1;
                        end
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    held_q   <= '0;
                    hold_p_q <= '0;
                    for (int i = 0; i < CHANNELS; i++) hcnt_q[i] <= '0;
                end else begin
                    held_q   <= held_d;
                    hold_p_q <= hold_p_d;
                    for (int i = 0; i < CHANNELS; i++) hcnt_q[i] <= hcnt_d[i];
                end
            end

            assign bus.btn_held   = held_q;
            assign bus.btn_hold_p = hold_p_q;
        end else begin : g_no_hold
            assign bus.btn_held   = '0;
            assign bus.btn_hold_p = '0;
        end
    endgenerate
endmodule
